// File: rtl/mux2_arb_pkg.sv
// ----------------------------------------------------------------------------
// mux2_arb_pkg
// Shared types and constants for the two-source packet arbiter:
//   arb_state_e : arbiter FSM states (IDLE, GNT_A, GNT_B)
//   PRIO_A/B    : round-robin priority encodings
//   CNT_W       : width of the per-source packet counters
//   owner_of()  : one-hot {B,A} grant decode from the FSM state
// ----------------------------------------------------------------------------
package mux2_arb_pkg;

    localparam int unsigned CNT_W = 8;

    localparam logic PRIO_A = 1'b0;
    localparam logic PRIO_B = 1'b1;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        GNT_A = 2'd1,
        GNT_B = 2'd2
    } arb_state_e;

    // One-hot {B,A} view of the current grant; 00 while idle.
    function automatic logic [1:0] owner_of(input arb_state_e s);
        logic [1:0] o;
        o = 2'b00;
        case (s)
            GNT_A:   o = 2'b01;
            GNT_B:   o = 2'b10;
            default: o = 2'b00;
        endcase
        return o;
    endfunction

endpackage : mux2_arb_pkg

// File: rtl/mux2.sv
// ----------------------------------------------------------------------------
// mux2
// Two-input datapath multiplexer with enable.
//   sel_i : 0 selects a_i, 1 selects b_i
//   en_i  : when low the output is forced to zero
//   a_i   : input 0 (W bits)
//   b_i   : input 1 (W bits)
//   y_o   : selected value (W bits), combinational
// ----------------------------------------------------------------------------
module mux2 #(
    parameter int unsigned W = 1
) (
    input  logic         sel_i,
    input  logic         en_i,
    input  logic [W-1:0] a_i,
    input  logic [W-1:0] b_i,
    output logic [W-1:0] y_o
);

    // Gated select: an idle arbiter presents all-zero to the output stage.
    always_comb begin
        y_o = '0;
        if (en_i) begin
            y_o = sel_i ? b_i : a_i;
        end
    end

endmodule : mux2

// File: rtl/mux2_arbiter.sv
// ----------------------------------------------------------------------------
// mux2_arbiter
// Shares one N-bit channel between packet sources A and B. The grant is held
// for a whole packet (until a last beat) and priority rotates round-robin
// between packets. Selected beats are captured into a one-entry output stage.
//
// Ports:
//   clk, rst_n                 clock (rising edge), async active-low reset
//   a_valid/a_data/a_last      source A beat
//   a_ready                    source A beat accepted this cycle
//   b_valid/b_data/b_last      source B beat
//   b_ready                    source B beat accepted this cycle
//   out_valid/out_data/out_last registered output beat
//   out_ready                  consumer accepts output beat
//   owner                      one-hot {B,A} current grant, 00 when idle
//   pkt_cnt_a, pkt_cnt_b       completed packets per source, wrapping
// ----------------------------------------------------------------------------
module mux2_arbiter
    import mux2_arb_pkg::*;
#(
    parameter int unsigned N = 8
) (
    input  logic             clk,
    input  logic             rst_n,

    input  logic             a_valid,
    input  logic [N-1:0]     a_data,
    input  logic             a_last,
    output logic             a_ready,

    input  logic             b_valid,
    input  logic [N-1:0]     b_data,
    input  logic             b_last,
    output logic             b_ready,

    output logic             out_valid,
    output logic [N-1:0]     out_data,
    output logic             out_last,
    input  logic             out_ready,

    output logic [1:0]       owner,
    output logic [CNT_W-1:0] pkt_cnt_a,
    output logic [CNT_W-1:0] pkt_cnt_b
);

    arb_state_e          state_q, state_d;
    logic                prio_q, prio_d;
    logic                out_valid_q, out_valid_d;
    logic [N-1:0]        out_data_q, out_data_d;
    logic                out_last_q, out_last_d;
    logic [CNT_W-1:0]    cnt_a_q, cnt_a_d;
    logic [CNT_W-1:0]    cnt_b_q, cnt_b_d;

    logic                load_c;
    logic                beat_c;
    logic                mux_sel_c;
    logic                mux_en_c;
    logic [N:0]          mux_y_c;

    // Output stage can take a new beat when empty or draining this cycle.
    assign load_c    = !out_valid_q || out_ready;

    assign mux_sel_c = (state_q == GNT_B);
    assign mux_en_c  = (state_q != IDLE);

    // Datapath select of {last, data} from the granted source.
    mux2 #(
        .W (N + 1)
    ) u_mux2 (
        .sel_i (mux_sel_c),
        .en_i  (mux_en_c),
        .a_i   ({a_last, a_data}),
        .b_i   ({b_last, b_data}),
        .y_o   (mux_y_c)
    );

    // Next-state, handshake and output-stage logic.
    always_comb begin
        state_d     = state_q;
        prio_d      = prio_q;
        cnt_a_d     = cnt_a_q;
        cnt_b_d     = cnt_b_q;
        out_valid_d = out_valid_q;
        out_data_d  = out_data_q;
        out_last_d  = out_last_q;
        a_ready     = 1'b0;
        b_ready     = 1'b0;
        beat_c      = 1'b0;

        case (state_q)
            IDLE: begin
                if (a_valid && (!b_valid || (prio_q == PRIO_A))) begin
                    state_d = GNT_A;
                end else if (b_valid) begin
                    state_d = GNT_B;
                end
            end

            GNT_A: begin
                a_ready = load_c;
                if (a_valid && load_c) begin
                    beat_c = 1'b1;
                    if (a_last) begin
                        state_d = IDLE;
                        prio_d  = PRIO_B;
                        cnt_a_d = cnt_a_q + CNT_W'(1);
                    end
                end
            end

            GNT_B: begin
                b_ready = load_c;
                if (b_valid && load_c) begin
                    beat_c = 1'b1;
                    if (b_last) begin
                        state_d = IDLE;
                        prio_d  = PRIO_A;
                        cnt_b_d = cnt_b_q + CNT_W'(1);
                    end
                end
            end

            default: begin
                state_d = IDLE;
            end
        endcase

        // A captured beat overrides the drain; data/last hold when draining.
        if (beat_c) begin
            out_valid_d = 1'b1;
            out_data_d  = mux_y_c[N-1:0];
            out_last_d  = mux_y_c[N];
        end else if (out_ready) begin
            out_valid_d = 1'b0;
        end
    end

    // State, priority, output stage and counters.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            prio_q      <= PRIO_A;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_last_q  <= 1'b0;
            cnt_a_q     <= '0;
            cnt_b_q     <= '0;
        end else begin
            state_q     <= state_d;
            prio_q      <= prio_d;
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            out_last_q  <= out_last_d;
            cnt_a_q     <= cnt_a_d;
            cnt_b_q     <= cnt_b_d;
        end
    end

    assign owner     = owner_of(state_q);
    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;
    assign out_last  = out_last_q;
    assign pkt_cnt_a = cnt_a_q;
    assign pkt_cnt_b = cnt_b_q;

endmodule : mux2_arbiter
